noc_input_port_buffer: RTL and testbench
========================================

Name: noc_input_port_buffer

Overview:
- Per-direction router input buffer for the 6x6 SMART mesh.
- Receives FlitFixed payloads (33-bit data) from the upstream link and stores them in a FIFO.
- Presents the head flit to the downstream route/switch-allocation stage with a valid/ready handshake.
- Returns one credit upstream per dequeued flit, which implements the Credit (1-bit) flow-control contract of the network.

Parameters:
- FLIT_WIDTH, 33: bits per flit; equals the width of FlitFixedData.
- DEPTH, 4: buffer entries; must be a power of two and ≥2. This also equals the upstream initial credit count.
- PTR_W, $clog2(DEPTH): pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flit_in_valid  input  1  upstream flit present this cycle; upstream only asserts while it holds a credit.
- flit_in  input  FLIT_WIDTH  incoming flit data.
- credit_out  output  1  one-cycle pulse; one credit returned upstream.
- flit_out_valid  output  1  head flit valid.
- flit_out  output  FLIT_WIDTH  head flit data.
- flit_out_ready  input  1  downstream consumes head this cycle when it is high together with flit_out_valid.
- occupancy  output  PTR_W+1  number of stored flits, 0..DEPTH.
- overflow_err  output  1  sticky error: a flit arrived while the buffer was full and no pop occurred.

Behaviour:
- Reset (synchronous; sampled on clk edge with reset=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - credit_out=0, flit_out_valid=0, occupancy=0, overflow_err=0.
  - flit_out contents are don't-care; the bench treats it as valid only under flit_out_valid.
  - Reset mid-operation discards all stored flits and any pending credit pulse. The upstream credit counter is reset by the same reset.
- Storage:
  - Circular FIFO of DEPTH entries.
  - Pointers are PTR_W bits and wrap naturally from DEPTH-1 to 0.
  - count is PTR_W+1 bits, saturating between 0 and DEPTH.
- Push: push = flit_in_valid & (count<DEPTH | pop).
  - On push: mem[wr_ptr]<=flit_in and wr_ptr increments.
- Pop: pop = flit_out_valid & flit_out_ready.
  - On pop: rd_ptr increments.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Output:
  - flit_out_valid = (count!=0), registered-state derived; no combinational path from flit_in.
  - flit_out = mem[rd_ptr].
  - Latency: a flit written at edge N is visible at flit_out from cycle N+1. There is no same-cycle bypass.
  - flit_out_ready while flit_out_valid=0 is ignored; pointers do not move.
  - flit_out must hold stable while flit_out_valid=1 and flit_out_ready=0.
- Credit:
  - credit_out is registered: credit_out <= pop.
  - It pulses exactly one cycle after each pop.
  - Back-to-back pops produce back-to-back credit pulses.
  - The number of credit pulses always equals the number of pops since reset.
- Full and simultaneous events:
  - Full with flit_in_valid and pop in the same cycle: both occur, count stays DEPTH, and no error.
  - Full with flit_in_valid and no pop: the flit is dropped, state is unchanged, and overflow_err is set to 1. It stays set until reset.
- Empty with flit_in_valid=1: the flit is written; flit_out_valid rises next cycle; there is no pop that cycle.
- occupancy = count.
- Assertions, simulation only:
  - No push dropped while credits are respected.
  - count never exceeds DEPTH.

Test Plan:
- Reset/idle: hold reset 3 cycles, then release with all inputs 0.
  - Required: all outputs 0 for 10 cycles.
- Single flit latency: flit_in=33'h1_2345_6789 valid at edge 0, flit_out_ready=0.
  - Required: at cycle 1, flit_out_valid=1, flit_out=33'h1_2345_6789, occupancy=1.
  - Then raise ready at cycle 3. Required: credit_out=1 at cycle 4 only, and occupancy=0.
- Fill, then wrap-around: push 4 flits with values 1..4 while ready=0.
  - Required: occupancy=4.
  - Then pop 2 and push 5,6. Required: output order is 1,2,3,4,5,6, with exactly 6 credit pulses total and overflow_err=0.
- Full with simultaneous push and pop: DEPTH=4 full, apply flit_in_valid=1 and ready=1 in the same cycle.
  - Required: occupancy stays 4, overflow_err=0, one credit pulse next cycle, and the new flit is delivered 4th after the popped one.
- Overflow: full, ready=0, flit_in_valid=1 with data 33'h0_DEAD_BEEF.
  - Required: overflow_err=1 from the next cycle and the data is never output.
  - Required: overflow_err is cleared only by reset.
- Reset mid-stream: 3 flits stored and a pop in cycle N, with reset asserted in cycle N+1.
  - Required: in the cycle after the reset edge, credit_out=0, occupancy=0, and flit_out_valid=0; the stored flits are not emitted afterwards.

Source files
------------

// File: rtl/noc_input_port_buffer.sv
// Router input-port flit buffer: circular FIFO with valid/ready head and a registered
// one-credit-per-pop return path to the upstream link.
module noc_input_port_buffer #(
  parameter int unsigned FLIT_WIDTH = 33,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flit_in_valid,
  input  logic [FLIT_WIDTH-1:0] flit_in,
  output logic                  credit_out,
  output logic                  flit_out_valid,
  output logic [FLIT_WIDTH-1:0] flit_out,
  input  logic                  flit_out_ready,
  output logic [PTR_W:0]        occupancy,
  output logic                  overflow_err
);

  localparam logic [PTR_W:0] CntMax = (PTR_W+1)'(DEPTH);

  logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
  logic [FLIT_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  credit_q, credit_d;
  logic                  overflow_q, overflow_d;
  logic                  full, push, pop;

  always_comb begin
    full       = (count_q == CntMax);
    pop        = (count_q != '0) & flit_out_ready;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    push       = flit_in_valid & (~full | pop);

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    credit_d   = pop;
    overflow_d = overflow_q | (flit_in_valid & full & ~pop);

    if (push) begin
      mem_d[wr_ptr_q] = flit_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage needs no reset; validity is carried entirely by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign flit_out_valid = (count_q != '0);
  assign flit_out       = mem_q[rd_ptr_q];
  assign occupancy      = count_q;
  assign credit_out     = credit_q;
  assign overflow_err   = overflow_q;

  assert property (@(posedge clk) disable iff (reset) count_q <= CntMax);

  // Upstream holds DEPTH - count - pending credit; a credited flit must never be dropped.
  assert property (@(posedge clk) disable iff (reset)
    (flit_in_valid && !overflow_q && ((32'(count_q) + 32'(credit_q)) < DEPTH)) |-> push);

endmodule

// File: tb/tb_noc_input_port_buffer.sv
// Directed, table-driven bench for noc_input_port_buffer (DEPTH=4, 33-bit flits).
module tb_noc_input_port_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flit_in_valid;
  logic [32:0] flit_in;
  logic        credit_out;
  logic        flit_out_valid;
  logic [32:0] flit_out;
  logic        flit_out_ready;
  logic [2:0]  occupancy;
  logic        overflow_err;

  noc_input_port_buffer #(
    .FLIT_WIDTH(33),
    .DEPTH     (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flit_in_valid (flit_in_valid),
    .flit_in       (flit_in),
    .credit_out    (credit_out),
    .flit_out_valid(flit_out_valid),
    .flit_out      (flit_out),
    .flit_out_ready(flit_out_ready),
    .occupancy     (occupancy),
    .overflow_err  (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [32:0] d;
    logic        r;
    logic        ev;
    logic [32:0] ed;
    int          eocc;
    logic        ecr;
    logic        eerr;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic rst, input logic v, input logic [32:0] d, input logic r,
                     input logic ev, input logic [32:0] ed, input int eocc, input logic ecr,
                     input logic eerr);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.r = r;
    t.ev = ev; t.ed = ed; t.eocc = eocc; t.ecr = ecr; t.eerr = eerr;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 64'(flit_out_valid), 64'd0);
    chk({tag, " credit"}, 64'(credit_out), 64'd0);
    chk({tag, " occ"}, 64'(occupancy), 64'd0);
    chk({tag, " ovf"}, 64'(overflow_err), 64'd0);
  endtask

  localparam logic [32:0] H1 = 33'h1_2345_6789;
  localparam logic [32:0] DB = 33'h0_DEAD_BEEF;

  initial begin
    int   credit_cnt;
    int   exp_pops;
    logic prev_ev;

    reset = 1'b1; flit_in_valid = 1'b0; flit_in = '0; flit_out_ready = 1'b0;

    // Single flit latency and credit timing
    add(0, 1, H1, 0, 1, H1, 1, 0, 0);
    add(0, 0, 0,  0, 1, H1, 1, 0, 0);
    add(0, 0, 0,  0, 1, H1, 1, 0, 0);
    add(0, 0, 0,  1, 0, 0,  0, 1, 0);
    add(0, 0, 0,  0, 0, 0,  0, 0, 0);
    // Fill, partial drain, refill across the pointer wrap
    for (int i = 1; i <= 4; i++) add(0, 1, 33'(i), 0, 1, 33'd1, i, 0, 0);
    add(0, 0, 0, 1, 1, 33'd2, 3, 1, 0);
    add(0, 0, 0, 1, 1, 33'd3, 2, 1, 0);
    add(0, 1, 33'd5, 0, 1, 33'd3, 3, 0, 0);
    add(0, 1, 33'd6, 0, 1, 33'd3, 4, 0, 0);
    add(0, 0, 0, 1, 1, 33'd4, 3, 1, 0);
    add(0, 0, 0, 1, 1, 33'd5, 2, 1, 0);
    add(0, 0, 0, 1, 1, 33'd6, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0,     0, 1, 0);
    add(0, 0, 0, 1, 0, 0,     0, 0, 0);  // ready while empty is ignored
    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) add(0, 1, 33'(7 + i), 0, 1, 33'd7, i + 1, 0, 0);
    add(0, 1, 33'd11, 1, 1, 33'd8, 4, 1, 0);
    add(0, 0, 0, 1, 1, 33'd9,  3, 1, 0);
    add(0, 0, 0, 1, 1, 33'd10, 2, 1, 0);
    add(0, 0, 0, 1, 1, 33'd11, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0,      0, 1, 0);
    add(0, 0, 0, 0, 0, 0,      0, 0, 0);
    // Overflow: dropped flit, sticky error until reset
    for (int i = 0; i < 4; i++) add(0, 1, 33'(21 + i), 0, 1, 33'd21, i + 1, 0, 0);
    add(0, 1, DB, 0, 1, 33'd21, 4, 0, 1);
    add(0, 0, 0,  0, 1, 33'd21, 4, 0, 1);
    add(0, 0, 0,  1, 1, 33'd22, 3, 1, 1);
    add(0, 0, 0,  1, 1, 33'd23, 2, 1, 1);
    add(0, 0, 0,  1, 1, 33'd24, 1, 1, 1);
    add(0, 0, 0,  1, 0, 0,      0, 1, 1);
    add(0, 0, 0,  0, 0, 0,      0, 0, 1);
    add(1, 0, 0,  0, 0, 0,      0, 0, 0);
    // Reset one cycle after a pop with flits still stored
    for (int i = 0; i < 3; i++) add(0, 1, 33'(31 + i), 0, 1, 33'd31, i + 1, 0, 0);
    add(0, 0, 0, 1, 1, 33'd32, 2, 1, 0);
    add(1, 0, 0, 1, 0, 0,      0, 0, 0);
    add(0, 0, 0, 1, 0, 0,      0, 0, 0);
    add(0, 0, 0, 0, 0, 0,      0, 0, 0);

    repeat (3) step();
    chk_idle("reset");
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk_idle("idle");
    end

    credit_cnt = 0;
    exp_pops   = 0;
    prev_ev    = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      reset          = vecs[i].rst;
      flit_in_valid  = vecs[i].v;
      flit_in        = vecs[i].d;
      flit_out_ready = vecs[i].r;
      if (prev_ev && vecs[i].r && !vecs[i].rst) exp_pops++;
      step();
      chk({tag, " valid"}, 64'(flit_out_valid), 64'(vecs[i].ev));
      if (vecs[i].ev) chk({tag, " data"}, 64'(flit_out), 64'(vecs[i].ed));
      chk({tag, " occ"}, 64'(occupancy), 64'(vecs[i].eocc));
      chk({tag, " credit"}, 64'(credit_out), 64'(vecs[i].ecr));
      chk({tag, " ovf"}, 64'(overflow_err), 64'(vecs[i].eerr));
      if (credit_out) credit_cnt++;
      prev_ev = vecs[i].ev;
    end
    reset = 1'b0; flit_in_valid = 1'b0; flit_out_ready = 1'b0;

    chk("credit total", 64'(credit_cnt), 64'(exp_pops));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
